// File: rtl/issue_select_ctrl.sv
// Single-issue oldest-ready select with per-row result latency countdown; issue is registered 1 cycle after grant.
// No backpressure on outputs; fu_ready gates per-row eligibility. Optional counters under ISSUE_SELECT_PERF_EN.
module issue_select_ctrl #(
    parameter int NUM_ROWS = 8,
    parameter int NUM_FUS  = 4,
    parameter int LAT_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_en,
    input  logic [$clog2(NUM_ROWS)-1:0] alloc_row,
    input  logic [$clog2(NUM_FUS)-1:0]  alloc_fu,
    input  logic [LAT_W-1:0]            alloc_lat,
    input  logic [NUM_ROWS-1:0]         request_vector,
    input  logic [NUM_FUS-1:0]          fu_ready,
    input  logic                        flush,
    output logic                        issue_valid,
    output logic [$clog2(NUM_ROWS)-1:0] issue_row,
    output logic [$clog2(NUM_FUS)-1:0]  issue_fu,
    output logic [NUM_ROWS-1:0]         wakeup_vector,
    output logic [NUM_ROWS-1:0]         free_vector
`ifdef ISSUE_SELECT_PERF_EN
    ,
    output logic [31:0]                 perf_issue_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int FW = $clog2(NUM_FUS);

    logic [NUM_ROWS-1:0]                valid;
    logic [NUM_ROWS-1:0]                issued;
    logic [NUM_ROWS-1:0][FW-1:0]        fu;
    logic [NUM_ROWS-1:0][LAT_W-1:0]     lat;
    logic [NUM_ROWS-1:0][LAT_W-1:0]     countdown;
    // age[r][j] set means row j was allocated before row r
    logic [NUM_ROWS-1:0][NUM_ROWS-1:0]  age;

    logic [NUM_ROWS-1:0]                pending;
    logic [NUM_ROWS-1:0]                eligible;
    logic [NUM_ROWS-1:0]                expiring;
    logic [NUM_ROWS-1:0]                grant;
    logic [RW-1:0]                      grant_row;
    logic                               grant_any;

    always_comb begin
        pending  = '0;
        eligible = '0;
        expiring = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            pending[r]  = valid[r] & ~issued[r] & request_vector[r];
            eligible[r] = pending[r] & fu_ready[fu[r]];
            expiring[r] = valid[r] & (countdown[r] == LAT_W'(1));
        end
    end

    // At most one eligible row has no eligible older row, so grant is one-hot
    always_comb begin
        grant     = '0;
        grant_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            grant[r] = eligible[r] & ~|(age[r] & eligible);
            if (grant[r])
                grant_row = RW'(r);
        end
    end

    assign grant_any     = |grant;
    assign wakeup_vector = expiring;
    assign free_vector   = expiring;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid       <= '0;
            issued      <= '0;
            countdown   <= '0;
            age         <= '0;
            issue_valid <= 1'b0;
            if (rst) begin
                issue_row <= '0;
                issue_fu  <= '0;
            end
        end else begin
            issue_valid <= grant_any;
            if (grant_any) begin
                issue_row <= grant_row;
                issue_fu  <= fu[grant_row];
            end
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (countdown[r] != '0)
                    countdown[r] <= countdown[r] - 1'b1;
                if (grant[r]) begin
                    issued[r]    <= 1'b1;
                    countdown[r] <= (lat[r] == '0) ? LAT_W'(1) : lat[r];
                end
                if (expiring[r]) begin
                    valid[r]  <= 1'b0;
                    issued[r] <= 1'b0;
                    for (int j = 0; j < NUM_ROWS; j++)
                        age[j][r] <= 1'b0;
                end
            end
            if (alloc_en) begin
                valid[alloc_row]  <= 1'b1;
                issued[alloc_row] <= 1'b0;
                // rows leaving this cycle must not be recorded as older
                for (int j = 0; j < NUM_ROWS; j++)
                    age[alloc_row][j] <= (j != int'(alloc_row)) && valid[j] && !expiring[j];
                for (int j = 0; j < NUM_ROWS; j++)
                    age[j][alloc_row] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            fu[alloc_row]  <= alloc_fu;
            lat[alloc_row] <= alloc_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && alloc_en)
            assert (!valid[alloc_row]);
    end

`ifdef ISSUE_SELECT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue_valid)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (|pending && !(|eligible))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_select_ctrl.sv
// Directed bench for issue_select_ctrl: stimulus queues per-cycle expected outputs, a negedge monitor compares.
module tb_issue_select_ctrl;

    logic       clk;
    logic       rst;
    logic       alloc_en;
    logic [2:0] alloc_row;
    logic [1:0] alloc_fu;
    logic [2:0] alloc_lat;
    logic [7:0] request_vector;
    logic [3:0] fu_ready;
    logic       flush;
    logic       issue_valid;
    logic [2:0] issue_row;
    logic [1:0] issue_fu;
    logic [7:0] wakeup_vector;
    logic [7:0] free_vector;

    issue_select_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_en       (alloc_en),
        .alloc_row      (alloc_row),
        .alloc_fu       (alloc_fu),
        .alloc_lat      (alloc_lat),
        .request_vector (request_vector),
        .fu_ready       (fu_ready),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_row      (issue_row),
        .issue_fu       (issue_fu),
        .wakeup_vector  (wakeup_vector),
        .free_vector    (free_vector)
    );

    typedef struct {
        int         cyc;
        bit         iv;
        int         row;
        int         fu;
        logic [7:0] wake;
        logic [7:0] free_v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid || (|wakeup_vector) || (|free_vector)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: cyc=%0d iv=%0b row=%0d fu=%0d wake=%02h free=%02h, want no output",
                             cyc, issue_valid, issue_row, issue_fu, wakeup_vector, free_vector);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ok = (mon_e.cyc == cyc) && (issue_valid == mon_e.iv) &&
                             (!mon_e.iv || (int'(issue_row) == mon_e.row && int'(issue_fu) == mon_e.fu)) &&
                             (wakeup_vector == mon_e.wake) && (free_vector == mon_e.free_v);
                    if (!mon_ok) begin
                        errors++;
                        $display("FAIL out_c%0d: got cyc=%0d iv=%0b row=%0d fu=%0d wake=%02h free=%02h, want cyc=%0d iv=%0b row=%0d fu=%0d wake=%02h free=%02h",
                                 mon_e.cyc, cyc, issue_valid, issue_row, issue_fu, wakeup_vector, free_vector,
                                 mon_e.cyc, mon_e.iv, mon_e.row, mon_e.fu, mon_e.wake, mon_e.free_v);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                mon_e = exp_q.pop_front();
                $display("FAIL missing_out_c%0d: got no output at cyc=%0d, want iv=%0b row=%0d fu=%0d wake=%02h free=%02h",
                         mon_e.cyc, cyc, mon_e.iv, mon_e.row, mon_e.fu, mon_e.wake, mon_e.free_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_out(input int c, input bit iv, input int row, input int fu,
                              input logic [7:0] w, input logic [7:0] f);
        exp_t e;
        e.cyc = c; e.iv = iv; e.row = row; e.fu = fu; e.wake = w; e.free_v = f;
        exp_q.push_back(e);
    endtask

    task automatic alloc(input int row, input int fu, input int lat);
        alloc_en  = 1'b1;
        alloc_row = 3'(row);
        alloc_fu  = 2'(fu);
        alloc_lat = 3'(lat);
        step();
        alloc_en  = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    int t;

    initial begin
        rst            = 1'b1;
        alloc_en       = 1'b0;
        alloc_row      = '0;
        alloc_fu       = '0;
        alloc_lat      = '0;
        request_vector = '0;
        fu_ready       = 4'hF;
        flush          = 1'b0;

        // reset state, then idle with every row requesting
        step();
        step();
        #3;
        check("reset_issue_valid", int'(issue_valid), 0);
        check("reset_wakeup", int'(wakeup_vector), 0);
        check("reset_free", int'(free_vector), 0);
        rst = 1'b0;
        request_vector = 8'hFF;
        idle(10);
        request_vector = 8'h00;

        // age order 5, 2, 7
        alloc(5, 0, 1);
        alloc(2, 0, 1);
        alloc(7, 0, 1);
        request_vector = 8'hA4;
        t = cyc;
        expect_out(t + 1, 1, 5, 0, 8'h20, 8'h20);
        expect_out(t + 2, 1, 2, 0, 8'h04, 8'h04);
        expect_out(t + 3, 1, 7, 0, 8'h80, 8'h80);
        idle(5);
        request_vector = 8'h00;
        idle(2);

        // older row 1 blocked on fu 2 while younger row 3 goes
        alloc(1, 2, 1);
        alloc(3, 0, 1);
        fu_ready = 4'h1;
        request_vector = 8'h0A;
        t = cyc;
        expect_out(t + 1, 1, 3, 0, 8'h08, 8'h08);
        expect_out(t + 4, 1, 1, 2, 8'h02, 8'h02);
        idle(3);
        fu_ready = 4'h5;
        idle(3);
        fu_ready = 4'hF;
        request_vector = 8'h00;
        idle(2);

        // latency 3; request held to catch any re-grant
        alloc(4, 1, 3);
        request_vector = 8'h10;
        t = cyc;
        expect_out(t + 1, 1, 4, 1, 8'h00, 8'h00);
        expect_out(t + 3, 0, 0, 0, 8'h10, 8'h10);
        idle(6);
        request_vector = 8'h00;
        idle(2);

        // two rows waking in the same cycle
        alloc(0, 0, 3);
        alloc(6, 3, 2);
        request_vector = 8'h41;
        t = cyc;
        expect_out(t + 1, 1, 0, 0, 8'h00, 8'h00);
        expect_out(t + 2, 1, 6, 3, 8'h00, 8'h00);
        expect_out(t + 3, 0, 0, 0, 8'h41, 8'h41);
        idle(6);
        request_vector = 8'h00;
        idle(2);

        // flush mid-countdown; flush also beats a same-cycle alloc of row 5
        alloc(2, 1, 5);
        request_vector = 8'h04;
        t = cyc;
        expect_out(t + 1, 1, 2, 1, 8'h00, 8'h00);
        idle(3);
        flush     = 1'b1;
        alloc_en  = 1'b1;
        alloc_row = 3'd5;
        alloc_fu  = 2'd0;
        alloc_lat = 3'd1;
        step();
        flush    = 1'b0;
        alloc_en = 1'b0;
        alloc(2, 0, 1);
        request_vector = 8'h24;
        expect_out(t + 6, 1, 2, 0, 8'h04, 8'h04);
        idle(8);
        request_vector = 8'h00;
        idle(2);

        // reset together with flush mid-countdown clears issue_row/fu and kills the wakeup
        alloc(3, 2, 4);
        request_vector = 8'h08;
        t = cyc;
        expect_out(t + 1, 1, 3, 2, 8'h00, 8'h00);
        idle(2);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        #3;
        check("rst_issue_row", int'(issue_row), 0);
        check("rst_issue_fu", int'(issue_fu), 0);
        check("rst_issue_valid", int'(issue_valid), 0);
        rst   = 1'b0;
        flush = 1'b0;
        request_vector = 8'h00;
        idle(8);

        check("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_select_ctrl.md
Name: issue_select_ctrl

Overview:
Single-issue select and wakeup sequencer for the backend scheduler. It sits beside the wakeup logic and does the following:
- Takes the per-row request vector.
- Picks the oldest requesting row whose target functional unit (FU) can accept work.
- Issues that row to the FU.
- Times the row's result latency, then drives the clear (wakeup) and free events back into the dependency matrices.

It owns per-row age order, FU binding and latency countdown state.

Parameters:
NUM_ROWS, 8, scheduler rows (power of 2, >=2)
NUM_FUS, 4, functional units (power of 2, >=2)
LAT_W, 3, latency field width; latencies 1..2^LAT_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_en  in  1  write a new entry this cycle
alloc_row  in  clog2(NUM_ROWS)  row being allocated
alloc_fu  in  clog2(NUM_FUS)  FU the entry executes on
alloc_lat  in  LAT_W  result latency in cycles (0 treated as 1)
request_vector  in  NUM_ROWS  rows whose operands are ready (from wakeup logic)
fu_ready  in  NUM_FUS  FU can accept an op this cycle
flush  in  1  discard all entries
issue_valid  out  1  registered issue pulse
issue_row  out  clog2(NUM_ROWS)  issued row
issue_fu  out  clog2(NUM_FUS)  FU targeted
wakeup_vector  out  NUM_ROWS  rows whose results become available this cycle (drives clear lines)
free_vector  out  NUM_ROWS  rows released this cycle

Behaviour:
- State per row:
  - valid
  - issued
  - fu
  - lat
  - countdown (LAT_W)
  - age matrix row: age[r][j]=1 means j is older than r.
- Reset (rst=1 at posedge): all valid/issued/countdown/age cleared. issue_valid, wakeup_vector and free_vector are 0 the following cycle. issue_row and issue_fu are 0.
- Alloc at edge:
  - Sets valid[r], stores fu and lat, clears issued[r].
  - Sets age[r][j]=valid[j] for all j!=r.
  - Clears column age[j][r] for all j.
  - Allocating a row with valid=1 is illegal; simulation assertion required.
- Eligibility (combinational): eligible[r] = valid[r] & ~issued[r] & request_vector[r] & fu_ready[fu[r]].
- Grant: the unique eligible r with no eligible j where age[r][j]=1.
- Grant at cycle t:
  - At edge t/t+1: issued[r] is set.
  - At edge t/t+1: countdown[r] is loaded with max(lat,1).
  - Cycle t+1: issue_valid=1 with issue_row=r and issue_fu=fu[r].
  - No grant means issue_valid=0 next cycle.
- Countdown:
  - Each cycle, every nonzero countdown decrements.
  - wakeup_vector[r]=1 in the cycle countdown[r]==1, which is cycle t+L with L=max(lat,1). For L=1 this is the same cycle as issue_valid.
  - In that same cycle free_vector[r]=1.
  - At the following edge valid[r] clears, its age column clears, and the row can be reallocated.
- Multiple rows may wake or free in the same cycle; all bits are asserted together.
- Rows become free only after wakeup, so tags are never reused while a wakeup is pending.
- An issued row never re-grants even if request_vector[r] stays high.
- flush at edge:
  - Clears all valid, issued, countdowns and age bits.
  - Next cycle: issue_valid=0, wakeup_vector=0, free_vector=0.
  - flush dominates alloc in the same cycle.
- rst dominates flush.
- Mid-countdown reset or flush: no wakeup is ever produced for the discarded rows.

Optional Feature:
ISSUE_SELECT_PERF_EN:
- When defined, adds outputs perf_issue_cnt [31:0] and perf_stall_cnt [31:0].
- perf_issue_cnt increments on each issue_valid cycle.
- perf_stall_cnt increments each cycle where some row has valid & ~issued & request_vector but none is eligible (FU busy).
- Both counters reset to 0 on rst, are not cleared by flush, and wrap modulo 2^32.
- When not defined, the ports and logic are absent.

Test Plan:
1. Reset and idle: after rst, with request_vector=0xFF and no allocs -> issue_valid, wakeup_vector and free_vector stay 0 for 10 cycles.
2. Age order:
   - Stimulus: alloc rows 5, 2, 7 (fu 0, lat 1) in consecutive cycles; then request_vector=0xA4 with fu_ready=0xF.
   - Required: issues appear in order 5, 2, 7 on three consecutive cycles.
   - Required: each issued row shows wakeup_vector and free_vector bits in its issue cycle.
3. FU blocking:
   - Stimulus: row 1 (older, fu 2) and row 3 (fu 0) both request; fu_ready=0x1.
   - Required: row 3 issues first; row 1 issues one cycle after fu_ready[2] rises.
4. Latency timing: row 4 with lat 3 granted at cycle 10 -> issue_valid in cycle 11; wakeup_vector=0x10 and free_vector=0x10 in cycle 13 only.
5. Simultaneous wakeups:
   - Stimulus: row 0 (lat 3) issued at cycle t; row 6 (lat 2) issued at t+1.
   - Required: wakeup_vector=0x41 in cycle t+3.
6. Flush mid-countdown: row 2 (lat 5) issued, flush asserted 2 cycles later -> no wakeup_vector or free_vector bit for row 2 ever appears, and row 2 is reallocatable the next cycle.
